// File: rtl/qbus_pkg.sv
// Shared definitions for the QBUS console TTY: register offsets, bit positions
// and the serial FSM encodings used by both the bus front end and the UART.
package qbus_pkg;

    typedef enum logic [1:0] {
        REG_RCSR = 2'd0,
        REG_RBUF = 2'd1,
        REG_XCSR = 2'd2,
        REG_XBUF = 2'd3
    } reg_off_t;

    localparam int CSR_FLAG_BIT  = 7;
    localparam int CSR_IE_BIT    = 6;
    localparam int RBUF_OVR_BIT  = 14;
    localparam int RBUF_FERR_BIT = 15;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    function automatic logic [15:0] csr_word(input logic flag, input logic ie);
        logic [15:0] w;
        w               = '0;
        w[CSR_FLAG_BIT] = flag;
        w[CSR_IE_BIT]   = ie;
        return w;
    endfunction

endpackage

// File: rtl/tty_uart.sv
// 8N1 serial transmitter and receiver, DIV clocks per bit.
// TX accepts a start pulse only while idle; RX pulses o_rx_valid once per frame.
module tty_uart
    import qbus_pkg::*;
#(
    parameter logic [15:0] DIV = 16'd434
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tx_start,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_ready,
    output logic       o_txd,
    input  logic       i_rxd,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_data,
    output logic       o_rx_stop
);

    localparam logic [15:0] DIV_M1  = DIV - 16'd1;
    localparam logic [15:0] HALF_M1 = (DIV >> 1) - 16'd1;

    tx_state_t   r_tx_state, w_tx_next;
    logic [15:0] r_tx_cnt;
    logic [2:0]  r_tx_bit;
    logic [7:0]  r_tx_sh;
    logic        r_txd;
    logic        w_tx_tick;

    rx_state_t   r_rx_state, w_rx_next;
    logic [15:0] r_rx_cnt;
    logic [2:0]  r_rx_bit;
    logic [7:0]  r_rx_sh;
    logic        r_rx_valid;
    logic        r_rx_stop;
    logic        r_rxd_s1, r_rxd_s2, r_rxd_d;
    logic        w_rx_tick;
    logic        w_rx_fall;

    assign w_tx_tick  = (r_tx_cnt == DIV_M1);
    assign o_tx_ready = (r_tx_state == TX_IDLE);
    assign o_txd      = r_txd;

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            TX_IDLE:  if (i_tx_start) w_tx_next = TX_START;
            TX_START: if (w_tx_tick) w_tx_next = TX_DATA;
            TX_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_next = TX_STOP;
            TX_STOP:  if (w_tx_tick) w_tx_next = TX_IDLE;
            default:  w_tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_next;
            if (r_tx_state == TX_IDLE || w_tx_tick) r_tx_cnt <= '0;
            else                                    r_tx_cnt <= r_tx_cnt + 16'd1;
            case (r_tx_state)
                TX_IDLE: if (i_tx_start) begin
                    r_tx_sh  <= i_tx_data;
                    r_tx_bit <= '0;
                    r_txd    <= 1'b0;
                end
                TX_START: if (w_tx_tick) begin
                    r_txd   <= r_tx_sh[0];
                    r_tx_sh <= r_tx_sh >> 1;
                end
                TX_DATA: if (w_tx_tick) begin
                    r_txd    <= (r_tx_bit == 3'd7) ? 1'b1 : r_tx_sh[0];
                    r_tx_sh  <= r_tx_sh >> 1;
                    r_tx_bit <= r_tx_bit + 3'd1;
                end
                default: r_txd <= 1'b1;
            endcase
        end
    end

    assign w_rx_tick  = (r_rx_cnt == DIV_M1);
    assign w_rx_fall  = r_rxd_d & ~r_rxd_s2;
    assign o_rx_valid = r_rx_valid;
    assign o_rx_data  = r_rx_sh;
    assign o_rx_stop  = r_rx_stop;

    // A start bit still high at its midpoint is treated as a glitch.
    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (w_rx_fall) w_rx_next = RX_START;
            RX_START: if (r_rx_cnt == HALF_M1) w_rx_next = r_rxd_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_next = RX_STOP;
            RX_STOP:  if (w_rx_tick) w_rx_next = RX_IDLE;
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_valid <= 1'b0;
            r_rxd_s1   <= 1'b1;
            r_rxd_s2   <= 1'b1;
            r_rxd_d    <= 1'b1;
        end else begin
            r_rxd_s1   <= i_rxd;
            r_rxd_s2   <= r_rxd_s1;
            r_rxd_d    <= r_rxd_s2;
            r_rx_state <= w_rx_next;
            r_rx_valid <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_cnt <= '0;
                    r_rx_bit <= '0;
                end
                RX_START: r_rx_cnt <= (r_rx_cnt == HALF_M1) ? 16'd0 : r_rx_cnt + 16'd1;
                RX_DATA: begin
                    if (w_rx_tick) begin
                        r_rx_cnt <= '0;
                        r_rx_sh  <= {r_rxd_s2, r_rx_sh[7:1]};
                        r_rx_bit <= r_rx_bit + 3'd1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
                default: begin
                    if (w_rx_tick) begin
                        r_rx_cnt   <= '0;
                        r_rx_valid <= 1'b1;
                        r_rx_stop  <= r_rxd_s2;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/qbus_tty.sv
// QBUS DL11-style console slave: four-register decode, bus handshake,
// vectored interrupts with daisy chain, around a tty_uart serial core.
module qbus_tty
    import qbus_pkg::*;
#(
    parameter logic [15:0] DIV    = 16'd434,
    parameter logic [15:0] BASE   = 16'o177560,
    parameter logic [15:0] VEC_RX = 16'o000060,
    parameter logic [15:0] VEC_TX = 16'o000064
) (
    input  logic        pin_clk,
    input  logic        pin_rst,
    input  logic [15:0] pin_ad_in_n,
    output logic [15:0] pin_ad_out_n,
    output logic        pin_ad_oe,
    input  logic        pin_sync_n,
    input  logic        pin_din_n,
    input  logic        pin_dout_n,
    input  logic        pin_wtbt_n,
    output logic        pin_rply_n,
    output logic        pin_virq_n,
    input  logic        pin_iako_in_n,
    output logic        pin_iako_out_n,
    input  logic        tty_rxd,
    output logic        tty_txd
);

    // Strobe vector: 0 sync, 1 din, 2 dout, 3 wtbt, 4 iako (all active-low)
    logic [4:0]  w_strb_raw;
    logic [4:0]  r_strb_s1, r_strb_s2;
    logic        r_sync_d;

    logic [15:0] w_ad_in;
    logic        w_sync_lo, w_din_lo, w_dout_lo, w_iako_lo, w_sync_fall;
    logic        w_sel_addr;

    logic        r_sel, r_byte;
    logic [2:0]  r_off;
    logic        r_busy, r_rply, r_oe, r_iak, r_iako_out;
    logic [15:0] r_ad_drv_n;

    logic        r_rx_ie, r_tx_ie, r_done, r_ovr, r_ferr, r_tx_req, r_ready_d;
    logic [7:0]  r_rbuf;

    logic        w_rd_go, w_wr_go, w_wr_ok, w_iak_go, w_release;
    logic        w_rx_req, w_pend, w_tx_start;
    logic [15:0] w_rd_data, w_vec;

    logic        w_tx_ready, w_rx_valid, w_rx_stop;
    logic [7:0]  w_rx_data;

    assign w_strb_raw  = {pin_iako_in_n, pin_wtbt_n, pin_dout_n, pin_din_n, pin_sync_n};
    assign w_ad_in     = ~pin_ad_in_n;
    assign w_sync_lo   = ~r_strb_s2[0];
    assign w_din_lo    = ~r_strb_s2[1];
    assign w_dout_lo   = ~r_strb_s2[2];
    assign w_iako_lo   = ~r_strb_s2[4];
    assign w_sync_fall = r_sync_d & w_sync_lo;
    assign w_sel_addr  = (w_ad_in[15:3] == BASE[15:3]);

    assign w_rx_req   = r_done & r_rx_ie;
    assign w_pend     = w_rx_req | r_tx_req;
    assign w_vec      = w_rx_req ? VEC_RX : VEC_TX;

    assign w_rd_go    = ~r_busy & w_sync_lo & w_din_lo & r_sel;
    assign w_wr_go    = ~r_busy & w_sync_lo & w_dout_lo & ~w_din_lo & r_sel;
    assign w_iak_go   = ~r_busy & ~w_sync_lo & w_din_lo & w_iako_lo & w_pend;
    assign w_release  = r_busy & ~w_din_lo & ~w_dout_lo;
    assign w_wr_ok    = w_wr_go & ~(r_byte & r_off[0]);
    assign w_tx_start = w_wr_ok & (r_off[2:1] == REG_XBUF);

    assign pin_rply_n     = ~r_rply;
    assign pin_ad_oe      = r_oe;
    assign pin_ad_out_n   = r_oe ? r_ad_drv_n : 16'hFFFF;
    assign pin_virq_n     = ~w_pend;
    assign pin_iako_out_n = r_iako_out;

    always_comb begin
        w_rd_data = '0;
        case (reg_off_t'(r_off[2:1]))
            REG_RCSR: w_rd_data = csr_word(r_done, r_rx_ie);
            REG_RBUF: begin
                w_rd_data[7:0]          = r_rbuf;
                w_rd_data[RBUF_OVR_BIT]  = r_ovr;
                w_rd_data[RBUF_FERR_BIT] = r_ferr;
            end
            REG_XCSR: w_rd_data = csr_word(w_tx_ready, r_tx_ie);
            default:  w_rd_data = '0;
        endcase
    end

    always_ff @(posedge pin_clk) begin
        if (pin_rst) begin
            r_strb_s1  <= '1;
            r_strb_s2  <= '1;
            r_sync_d   <= 1'b1;
            r_sel      <= 1'b0;
            r_busy     <= 1'b0;
            r_rply     <= 1'b0;
            r_oe       <= 1'b0;
            r_iak      <= 1'b0;
            r_iako_out <= 1'b1;
        end else begin
            r_strb_s1  <= w_strb_raw;
            r_strb_s2  <= r_strb_s1;
            r_sync_d   <= r_strb_s2[0];
            // While we own or are about to claim the acknowledge, block the chain.
            r_iako_out <= (w_pend | r_iak) ? 1'b1 : r_strb_s2[4];
            if (w_sync_fall) begin
                r_sel  <= w_sel_addr;
                r_off  <= w_ad_in[2:0];
                r_byte <= ~r_strb_s2[3];
            end
            if (w_rd_go || w_iak_go) begin
                r_busy     <= 1'b1;
                r_rply     <= 1'b1;
                r_oe       <= 1'b1;
                r_iak      <= w_iak_go;
                r_ad_drv_n <= ~(w_iak_go ? w_vec : w_rd_data);
            end else if (w_wr_go) begin
                r_busy <= 1'b1;
                r_rply <= 1'b1;
            end else if (w_release) begin
                r_busy <= 1'b0;
                r_rply <= 1'b0;
                r_oe   <= 1'b0;
                r_iak  <= 1'b0;
            end
        end
    end

    always_ff @(posedge pin_clk) begin
        if (pin_rst) begin
            r_rx_ie   <= 1'b0;
            r_tx_ie   <= 1'b0;
            r_done    <= 1'b0;
            r_ovr     <= 1'b0;
            r_ferr    <= 1'b0;
            r_rbuf    <= '0;
            r_tx_req  <= 1'b0;
            r_ready_d <= 1'b1;
        end else begin
            r_ready_d <= w_tx_ready;
            if (w_rd_go && r_off[2:1] == REG_RBUF) begin
                r_done <= 1'b0;
                r_ovr  <= 1'b0;
                r_ferr <= 1'b0;
            end
            if (w_rx_valid) begin
                r_rbuf <= w_rx_data;
                r_ferr <= ~w_rx_stop;
                r_ovr  <= r_done;
                r_done <= 1'b1;
            end
            if (w_tx_ready && !r_ready_d && r_tx_ie) r_tx_req <= 1'b1;
            if (w_iak_go && !w_rx_req)               r_tx_req <= 1'b0;
            if (w_wr_ok) begin
                case (reg_off_t'(r_off[2:1]))
                    REG_RCSR: r_rx_ie <= w_ad_in[CSR_IE_BIT];
                    REG_XCSR: begin
                        r_tx_ie <= w_ad_in[CSR_IE_BIT];
                        if (w_ad_in[CSR_IE_BIT] && !r_tx_ie && w_tx_ready) r_tx_req <= 1'b1;
                        else if (!w_ad_in[CSR_IE_BIT])                    r_tx_req <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    tty_uart #(
        .DIV(DIV)
    ) u_uart (
        .i_clk      (pin_clk),
        .i_rst      (pin_rst),
        .i_tx_start (w_tx_start),
        .i_tx_data  (w_ad_in[7:0]),
        .o_tx_ready (w_tx_ready),
        .o_txd      (tty_txd),
        .i_rxd      (tty_rxd),
        .o_rx_valid (w_rx_valid),
        .o_rx_data  (w_rx_data),
        .o_rx_stop  (w_rx_stop)
    );

endmodule

// File: tb/tb_qbus_tty.sv
// Bench for qbus_tty: directed bus/serial scenarios plus a randomized
// sequence, compared against a register-level model of the console.
module tb_qbus_tty;

    localparam logic [15:0] DIV = 16'd8;
    localparam int D = 8;
    localparam logic [15:0] A_RCSR = 16'o177560;
    localparam logic [15:0] A_RBUF = 16'o177562;
    localparam logic [15:0] A_XCSR = 16'o177564;
    localparam logic [15:0] A_XBUF = 16'o177566;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ad_in_n = 16'hFFFF;
    logic [15:0] ad_out_n;
    logic        ad_oe;
    logic        sync_n = 1'b1, din_n = 1'b1, dout_n = 1'b1, wtbt_n = 1'b1;
    logic        rply_n, virq_n;
    logic        iako_in_n = 1'b1;
    logic        iako_out_n;
    logic        rxd = 1'b1;
    logic        txd;

    qbus_tty #(.DIV(DIV)) dut (
        .pin_clk       (clk),
        .pin_rst       (rst),
        .pin_ad_in_n   (ad_in_n),
        .pin_ad_out_n  (ad_out_n),
        .pin_ad_oe     (ad_oe),
        .pin_sync_n    (sync_n),
        .pin_din_n     (din_n),
        .pin_dout_n    (dout_n),
        .pin_wtbt_n    (wtbt_n),
        .pin_rply_n    (rply_n),
        .pin_virq_n    (virq_n),
        .pin_iako_in_n (iako_in_n),
        .pin_iako_out_n(iako_out_n),
        .tty_rxd       (rxd),
        .tty_txd       (txd)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Register-level model of the console state
    logic       m_done, m_ovr, m_ferr, m_rx_ie, m_tx_ie, m_tx_req;
    logic [7:0] m_rbuf;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0o expected %0o", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_done = 0; m_ovr = 0; m_ferr = 0; m_rx_ie = 0; m_tx_ie = 0; m_tx_req = 0; m_rbuf = 0;
    endtask

    function automatic logic [15:0] exp_rcsr();
        return {8'h00, m_done, m_rx_ie, 6'b0};
    endfunction

    function automatic logic [15:0] exp_xcsr(input logic ready);
        return {8'h00, ready, m_tx_ie, 6'b0};
    endfunction

    function automatic logic [15:0] exp_rbuf();
        return {m_ferr, m_ovr, 6'b0, m_rbuf};
    endfunction

    function automatic logic exp_virq();
        return ~((m_done & m_rx_ie) | m_tx_req);
    endfunction

    task automatic bus_read(input logic [15:0] addr, output logic [15:0] data,
                            output int t_on, output int t_off, output bit ok);
        ok = 1; data = 16'hDEAD; t_on = 0; t_off = 0;
        ad_in_n = ~addr; wtbt_n = 1; sync_n = 0;
        tick(4);
        ad_in_n = '1; din_n = 0;
        while (rply_n !== 1'b0 && t_on < 20) begin tick(1); t_on++; end
        if (rply_n !== 1'b0) ok = 0;
        else if (ad_oe === 1'b1) data = ~ad_out_n;
        din_n = 1;
        while (rply_n !== 1'b1 && t_off < 20) begin tick(1); t_off++; end
        if (rply_n !== 1'b1 || ad_oe !== 1'b0) ok = 0;
        sync_n = 1;
        tick(2);
    endtask

    task automatic rd(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        logic [15:0] d; int a, b; bit ok;
        bus_read(addr, d, a, b, ok);
        check({tag, "_hs"}, ok, 1);
        check(tag, d, exp);
    endtask

    task automatic wr(input string tag, input logic [15:0] addr, input logic [15:0] data,
                      input bit byte_acc);
        int t; bit ok;
        t = 0; ok = 1;
        ad_in_n = ~addr; wtbt_n = byte_acc ? 1'b0 : 1'b1; sync_n = 0;
        tick(4);
        ad_in_n = ~data; wtbt_n = 1; dout_n = 0;
        while (rply_n !== 1'b0 && t < 20) begin tick(1); t++; end
        if (rply_n !== 1'b0) ok = 0;
        dout_n = 1; t = 0;
        while (rply_n !== 1'b1 && t < 20) begin tick(1); t++; end
        if (rply_n !== 1'b1) ok = 0;
        sync_n = 1; ad_in_n = '1;
        tick(2);
        check({tag, "_hs"}, ok, 1);
    endtask

    task automatic model_wr_xcsr(input logic [15:0] d);
        if (d[6] && !m_tx_ie) m_tx_req = 1;
        if (!d[6]) m_tx_req = 0;
        m_tx_ie = d[6];
    endtask

    task automatic iak(input string tag);
        int t; logic [15:0] v; logic hold;
        t = 0; v = 16'hDEAD; hold = 0;
        sync_n = 1; iako_in_n = 0; din_n = 0;
        while (rply_n !== 1'b0 && t < 20) begin tick(1); t++; end
        if (rply_n === 1'b0 && ad_oe === 1'b1) v = ~ad_out_n;
        hold = iako_out_n;
        din_n = 1; iako_in_n = 1;
        t = 0;
        while (rply_n !== 1'b1 && t < 20) begin tick(1); t++; end
        tick(2);
        check({tag, "_vec"}, v, (m_done & m_rx_ie) ? 16'o000060 : 16'o000064);
        check({tag, "_chain"}, hold, 1'b1);
        if (!(m_done & m_rx_ie)) m_tx_req = 0;
    endtask

    task automatic send_char(input logic [7:0] c, input logic stop);
        rxd = 0; tick(D);
        for (int i = 0; i < 8; i++) begin rxd = c[i]; tick(D); end
        rxd = stop; tick(D);
        rxd = 1; tick(2 * D);
        m_ovr = m_done; m_ferr = ~stop; m_rbuf = c; m_done = 1;
    endtask

    task automatic tx_mon(output logic [9:0] frame, output bit ok);
        int t;
        t = 0; ok = 1; frame = '1;
        while (txd !== 1'b0 && t < 60) begin tick(1); t++; end
        if (txd !== 1'b0) begin ok = 0; return; end
        tick(D / 2);
        for (int i = 0; i < 10; i++) begin
            frame[i] = txd;
            if (i < 9) tick(D);
        end
    endtask

    task automatic tx_char(input string tag, input logic [7:0] c, input bit busy_chk);
        logic [9:0] f; bit ok;
        fork
            begin
                wr({tag, "_wr"}, A_XBUF, {8'h00, c}, 0);
                if (busy_chk) rd({tag, "_busy"}, A_XCSR, exp_xcsr(1'b0));
            end
            tx_mon(f, ok);
        join
        check({tag, "_start"}, ok, 1);
        check({tag, "_frame"}, f, {1'b1, c, 1'b0});
        tick(D);
        if (m_tx_ie) m_tx_req = 1;
        rd({tag, "_ready"}, A_XCSR, exp_xcsr(1'b1));
    endtask

    initial begin
        logic [15:0] d; int t_on, t_off; bit ok, seen;
        int op; logic [7:0] c; logic [15:0] w;

        model_reset();
        tick(4);
        check("rst_rply", rply_n, 1'b1);
        check("rst_oe", ad_oe, 1'b0);
        check("rst_ad", ad_out_n, 16'hFFFF);
        check("rst_virq", virq_n, 1'b1);
        check("rst_iako", iako_out_n, 1'b1);
        check("rst_txd", txd, 1'b1);
        rst = 0;
        tick(2);

        iako_in_n = 0; tick(4);
        check("iako_pass_lo", iako_out_n, 1'b0);
        iako_in_n = 1; tick(4);
        check("iako_pass_hi", iako_out_n, 1'b1);

        bus_read(A_XCSR, d, t_on, t_off, ok);
        check("xcsr_rst_hs", ok, 1);
        check("xcsr_rst", d, 16'o000200);
        check("rply_on_lat", t_on, 3);
        check("rply_off_lat", t_off, 3);

        ad_in_n = ~16'o177570; sync_n = 0; tick(4);
        ad_in_n = '1; din_n = 0; seen = 0;
        repeat (64) begin tick(1); if (rply_n !== 1'b1 || ad_oe !== 1'b0) seen = 1; end
        check("unsel_quiet", seen, 0);
        din_n = 1; tick(3); sync_n = 1; tick(2);

        wr("odd_byte", 16'o177565, 16'o000100, 1);
        rd("odd_byte_xcsr", A_XCSR, exp_xcsr(1'b1));

        tx_char("tx101", 8'o101, 1);

        rxd = 0; tick(2); rxd = 1; tick(2 * D);
        rd("glitch_rcsr", A_RCSR, exp_rcsr());

        send_char(8'h5A, 1);
        rd("rx5a_rcsr", A_RCSR, 16'o000200);
        rd("rx5a_rbuf", A_RBUF, 16'o000132);
        m_done = 0; m_ovr = 0; m_ferr = 0;
        rd("rx5a_rcsr2", A_RCSR, 16'o000000);

        send_char(8'h31, 1);
        send_char(8'hC4, 1);
        rd("ovr_rbuf", A_RBUF, 16'o040000 | 16'h00C4);
        m_done = 0; m_ovr = 0; m_ferr = 0;
        send_char(8'h77, 0);
        rd("ferr_rbuf", A_RBUF, 16'o100000 | 16'h0077);
        m_done = 0; m_ovr = 0; m_ferr = 0;

        for (int k = 0; k < 16; k++) begin
            op = $urandom_range(0, 5);
            c  = 8'($urandom);
            case (op)
                0, 1: send_char(c, ($urandom_range(0, 5) != 0));
                2: begin
                    rd("rnd_rbuf", A_RBUF, exp_rbuf());
                    m_done = 0; m_ovr = 0; m_ferr = 0;
                end
                3: rd("rnd_rcsr", A_RCSR, exp_rcsr());
                4: tx_char("rnd_tx", c, 0);
                default: begin
                    w = {9'b0, 1'($urandom), 6'b0};
                    wr("rnd_ie", A_RCSR, w, 0);
                    m_rx_ie = w[6];
                end
            endcase
            check("rnd_virq", virq_n, exp_virq());
        end
        rd("rnd_end_rbuf", A_RBUF, exp_rbuf());
        m_done = 0; m_ovr = 0; m_ferr = 0;
        wr("rx_ie_on", A_RCSR, 16'o000100, 0);
        m_rx_ie = 1;

        send_char(8'h41, 1);
        check("irq_rx_virq", virq_n, 1'b0);
        wr("tx_ie_on", A_XCSR, 16'o000100, 0);
        model_wr_xcsr(16'o000100);
        iak("iak1");
        iak("iak2");
        rd("irq_rbuf", A_RBUF, exp_rbuf());
        m_done = 0; m_ovr = 0; m_ferr = 0;
        iak("iak3");
        check("irq_clear_virq", virq_n, exp_virq());
        wr("tx_ie_off", A_XCSR, 16'o000000, 0);
        model_wr_xcsr(16'o000000);
        wr("rx_ie_off", A_RCSR, 16'o000000, 0);
        m_rx_ie = 0;

        wr("tx_abort_wr", A_XBUF, 16'o000000, 0);
        tick(3 * D);
        check("tx_abort_mid", txd, 1'b0);
        rst = 1;
        tick(1);
        check("tx_abort_txd", txd, 1'b1);
        tick(2);
        rst = 0;
        model_reset();
        seen = 0;
        repeat (12 * D) begin tick(1); if (txd !== 1'b1) seen = 1; end
        check("tx_abort_quiet", seen, 0);
        rd("tx_abort_xcsr", A_XCSR, exp_xcsr(1'b1));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/qbus_tty.md
QBUS_TTY -- requirements
Module: qbus_tty

Interface
REQ-001 Parameter DIV, default 16'd434, clocks per serial bit (minimum 4).
REQ-002 Parameter BASE, default 16'o177560, base address of the four registers.
REQ-003 Parameter VEC_RX, default 16'o000060; parameter VEC_TX, default 16'o000064.
REQ-004 pin_clk  in  1  single clock; all logic on its rising edge.
REQ-005 pin_rst  in  1  reset, synchronous, active-high.
REQ-006 pin_ad_in_n  in  16  inverted AD bus as received.
REQ-007 pin_ad_out_n  out  16  inverted AD bus drive value.
REQ-008 pin_ad_oe  out  1  AD bus output enable.
REQ-009 pin_sync_n, pin_din_n, pin_dout_n, pin_wtbt_n  in  1 each  QBUS strobes, active-low.
REQ-010 pin_rply_n  out  1  transaction reply, active-low.
REQ-011 pin_virq_n  out  1  vectored interrupt request, active-low.
REQ-012 pin_iako_in_n  in  1; pin_iako_out_n  out  1  interrupt acknowledge daisy chain.
REQ-013 tty_rxd  in  1; tty_txd  out  1  serial lines, idle high.

Function
REQ-014 Each bus strobe input shall pass through a 2-flop synchronizer; all timing below counts from the synchronized edge.
REQ-015 On falling sync_n, the block shall latch ~ad as addr and ~wtbt as byte flag; sel = (addr[15:3] == BASE[15:3]) & ~addr[2:0]==odd-word.
REQ-016 Register map: +0 RCSR (b7 done RO, b6 rx_ie RW), +2 RBUF (b7:0 data, b14 overrun, b15 frame error; RO), +4 XCSR (b7 ready RO, b6 tx_ie RW), +6 XBUF (WO, reads 0).
REQ-017 Read: din_n low & sync_n low & sel -> drive ~data with ad_oe=1 and rply_n=0 on the next clock; hold both until din_n high, then release both on the next clock.
REQ-018 Write: dout_n low & sel -> capture ~ad on that clock and assert rply_n on the next clock; release as in REQ-017. A byte write to an odd address shall be ignored.
REQ-019 Unselected addresses shall never assert rply_n or ad_oe.
REQ-020 Reading RBUF shall clear done, overrun and frame error.
REQ-021 TX FSM: IDLE -> START -> DATA(8, LSB first) -> STOP -> IDLE; each state lasts DIV clocks. A write to XBUF clears ready and starts START on the next clock. Ready sets on the clock STOP ends. A write to XBUF while not ready shall be ignored.
REQ-022 RX FSM: IDLE -> START -> DATA -> STOP. Entry on a falling synchronized tty_rxd edge. Sample at DIV/2 into START: if high, return to IDLE (glitch). Then sample every DIV clocks. At the STOP sample: load RBUF and set done; b15 = ~stop bit; b14 = done already set.
REQ-023 Interrupts:
- rx_req is a level: done & rx_ie.
- tx_req is a flag. It sets on ready rising while tx_ie=1, or on tx_ie 0->1 while ready=1. It clears on tx acknowledge or when tx_ie is cleared.
- pin_virq_n = ~(rx_req | tx_req).
REQ-024 Acknowledge: iako_in_n low & din_n low & sync_n high & a request pending -> drive the vector with rply as in REQ-017, and hold iako_out_n high. rx has priority; on simultaneous requests tx stays pending. With no request pending, iako_out_n shall follow iako_in_n.
REQ-025 An rx acknowledge shall not clear done; rx_req persists until RBUF is read or rx_ie is cleared.

Reset
REQ-026 While pin_rst=1, outputs shall be: rply_n=1, ad_oe=0, ad_out_n=16'hFFFF, virq_n=1, iako_out_n=1, tty_txd=1.
REQ-027 Reset state: both FSMs in IDLE, ready=1, done=0, both ie=0, tx_req=0, RBUF=0. Reset mid-character aborts the character with no partial output.

Structure
REQ-028 Register offsets, bit positions and FSM state encodings shall live in shared package qbus_pkg.
REQ-029 A single sub-module, tty_uart (TX+RX FSMs, DIV counters), shall be instantiated; the QBUS decode and interrupt logic stay in qbus_tty.

Verification
REQ-030 Reset, then read 177564 -> ad=~16'o000200, rply_n low 1 clock after synchronized din, released 1 clock after din_n high.
REQ-031 Write 16'o000101 to 177566 -> tty_txd shows start 0, bits 1,0,0,0,0,0,1,0, stop 1, each DIV clocks; XCSR b7 reads 0 during the frame and 1 after.
REQ-032 Serial in 8'h5A with a valid stop bit -> RCSR=16'o000200; RBUF read=16'o000132; a following RCSR read returns 0.
REQ-033 Two characters in with no RBUF read -> RBUF=16'o040000|second char. A stop bit forced low -> b15 set.
REQ-034 rx_ie=1, tx_ie=1, char received -> virq_n low; first iako returns 16'o000060, second returns 16'o000064 only after RBUF is read.
REQ-035 Read 177570 -> no rply_n for 64 clocks; assert pin_rst mid-TX-frame -> tty_txd=1 on the next clock and ready=1.
